// File: rtl/data_bus_bridge_pkg.sv
// ============================================================================
// Module : data_bus_bridge_pkg
// Brief  : Size encodings, FSM state type and beat-count helper for the bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_bus_bridge_pkg;

  localparam logic [1:0] SIZ_BYTE  = 2'd0;
  localparam logic [1:0] SIZ_HALF  = 2'd1;
  localparam logic [1:0] SIZ_WORD  = 2'd2;
  localparam logic [1:0] SIZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of 16-bit bus beats needed for one CPU access of the given size.
  function automatic logic [2:0] beat_count(input logic [1:0] siz);
    case (siz)
      SIZ_WORD:  return 3'd2;
      SIZ_DWORD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_bus_bridge_load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Combinational sign/zero extension of assembled read data by size
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
  import data_bus_bridge_pkg::*;
(
  input  logic [1:0]  i_siz,
  input  logic        i_signed,
  input  logic        i_adr0,
  input  logic [63:0] i_raw,
  output logic [63:0] o_ext
);

  logic [7:0] w_byte;

  always_comb begin
    // A byte access only ever fills lane 0; the address LSB picks the half.
    w_byte = i_adr0 ? i_raw[15:8] : i_raw[7:0];
    case (i_siz)
      SIZ_BYTE: o_ext = {{56{i_signed & w_byte[7]}}, w_byte};
      SIZ_HALF: o_ext = {{48{i_signed & i_raw[15]}}, i_raw[15:0]};
      SIZ_WORD: o_ext = {{32{i_signed & i_raw[31]}}, i_raw[31:0]};
      default:  o_ext = i_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_bus_bridge.sv
// ============================================================================
// Module : data_bus_bridge
// Brief  : 64-bit CPU data port to 16-bit Wishbone classic multi-beat bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dcyc_i,
  input  logic              dstb_i,
  input  logic              dwe_i,
  input  logic [1:0]        dsiz_i,
  input  logic              dsigned_i,
  input  logic [ADDR_W-1:0] dadr_i,
  input  logic [63:0]       ddat_i,
  output logic [63:0]       ddat_o,
  output logic              dack_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [15:0]       wb_dat_o,
  output logic [1:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [15:0]       wb_dat_i,
  input  logic              wb_ack_i
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_adr;
  logic [63:0]       r_wdat;
  logic              r_we;
  logic [1:0]        r_siz;
  logic              r_sgn;
  logic [1:0]        r_beat;
  logic [63:0]       r_raw;

  logic              w_last;
  logic [1:0]        w_beat_nxt;
  logic [63:0]       w_raw_nxt;
  logic [63:0]       w_ext;

  // Aligned base (low siz bits cleared) plus two bytes per beat index.
  function automatic logic [ADDR_W-1:0] f_beat_adr(input logic [ADDR_W-1:0] adr,
                                                   input logic [1:0]        siz,
                                                   input logic [1:0]        k);
    logic [ADDR_W-1:0] m;
    m = ~((ADDR_W'(1) << siz) - ADDR_W'(1));
    return (adr & m) + (ADDR_W'(k) << 1);
  endfunction

  function automatic logic [15:0] f_beat_dat(input logic [63:0] dat,
                                             input logic [1:0]  siz,
                                             input logic [1:0]  k);
    if (siz == SIZ_BYTE) return {dat[7:0], dat[7:0]};
    return dat[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic [1:0] f_sel(input logic [1:0] siz, input logic a0);
    if (siz == SIZ_BYTE) return a0 ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  assign w_last     = ({1'b0, r_beat} + 3'd1) == beat_count(r_siz);
  assign w_beat_nxt = r_beat + 2'd1;

  always_comb begin
    w_raw_nxt = r_raw;
    w_raw_nxt[{r_beat, 4'b0000} +: 16] = wb_dat_i;
  end

  load_extend u_load_extend (
    .i_siz    (r_siz),
    .i_signed (r_sgn),
    .i_adr0   (r_adr[0]),
    .i_raw    (w_raw_nxt),
    .o_ext    (w_ext)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_adr    <= '0;
      r_wdat   <= '0;
      r_we     <= 1'b0;
      r_siz    <= SIZ_BYTE;
      r_sgn    <= 1'b0;
      r_beat   <= 2'd0;
      r_raw    <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= 2'b00;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      dack_o   <= 1'b0;
      ddat_o   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dcyc_i && dstb_i) begin
            r_adr    <= dadr_i;
            r_wdat   <= ddat_i;
            r_we     <= dwe_i;
            r_siz    <= dsiz_i;
            r_sgn    <= dsigned_i;
            r_beat   <= 2'd0;
            r_raw    <= '0;
            wb_adr_o <= f_beat_adr(dadr_i, dsiz_i, 2'd0);
            wb_dat_o <= f_beat_dat(ddat_i, dsiz_i, 2'd0);
            wb_sel_o <= f_sel(dsiz_i, dadr_i[0]);
            wb_we_o  <= dwe_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            r_state  <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (wb_ack_i) begin
            r_raw  <= w_raw_nxt;
            r_beat <= w_beat_nxt;
            if (w_last) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_we_o  <= 1'b0;
              dack_o   <= 1'b1;
              ddat_o   <= w_ext;
              r_state  <= ST_DONE;
            end else begin
              wb_adr_o <= f_beat_adr(r_adr, r_siz, w_beat_nxt);
              wb_dat_o <= f_beat_dat(r_wdat, r_siz, w_beat_nxt);
            end
          end
        end
        ST_DONE: begin
          dack_o  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
// ============================================================================
// Module : tb_data_bus_bridge
// Brief  : Directed table-driven bench for data_bus_bridge
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_bus_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dcyc_i, dstb_i, dwe_i, dsigned_i;
  logic [1:0]  dsiz_i;
  logic [63:0] dadr_i, ddat_i;
  logic [63:0] ddat_o;
  logic        dack_o;
  logic [63:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk_i = ~clk_i;

  data_bus_bridge #(.ADDR_W(64)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .dcyc_i    (dcyc_i),
    .dstb_i    (dstb_i),
    .dwe_i     (dwe_i),
    .dsiz_i    (dsiz_i),
    .dsigned_i (dsigned_i),
    .dadr_i    (dadr_i),
    .ddat_i    (ddat_i),
    .ddat_o    (ddat_o),
    .dack_o    (dack_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  typedef struct {
    logic [1:0]  siz;
    logic        we;
    logic        sgn;
    logic [63:0] adr;
    logic [63:0] wdat;
    logic [63:0] rlanes;
    int          waits;
    logic [63:0] exp_adr0;
    logic [1:0]  exp_sel;
    int          nbeats;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full access: accept, beats with wait states, DONE, and the idle cycle after.
  task automatic run_txn(input int idx, input vec_t v);
    logic [63:0] ea;
    logic [15:0] ed;
    dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = v.we; dsiz_i = v.siz;
    dsigned_i = v.sgn; dadr_i = v.adr; ddat_i = v.wdat;
    tick();
    dcyc_i = 1'b0; dstb_i = 1'b0; dadr_i = '0; ddat_i = '0;
    for (int k = 0; k < v.nbeats; k++) begin
      ea = v.exp_adr0 + 64'(2 * k);
      ed = (v.siz == 2'd0) ? {v.wdat[7:0], v.wdat[7:0]} : v.wdat[16*k +: 16];
      for (int w = 0; w <= v.waits; w++) begin
        wb_ack_i = (w == v.waits);
        wb_dat_i = v.rlanes[16*k +: 16];
        chk($sformatf("v%0d b%0d w%0d cyc", idx, k, w), 64'(wb_cyc_o), 64'd1);
        chk($sformatf("v%0d b%0d w%0d stb", idx, k, w), 64'(wb_stb_o), 64'd1);
        chk($sformatf("v%0d b%0d w%0d adr", idx, k, w), wb_adr_o, ea);
        chk($sformatf("v%0d b%0d w%0d sel", idx, k, w), 64'(wb_sel_o), 64'(v.exp_sel));
        chk($sformatf("v%0d b%0d w%0d we", idx, k, w), 64'(wb_we_o), 64'(v.we));
        chk($sformatf("v%0d b%0d w%0d dack", idx, k, w), 64'(dack_o), 64'd0);
        if (v.we) chk($sformatf("v%0d b%0d w%0d wdat", idx, k, w), 64'(wb_dat_o), 64'(ed));
        tick();
      end
      wb_ack_i = 1'b0;
    end
    chk($sformatf("v%0d done dack", idx), 64'(dack_o), 64'd1);
    chk($sformatf("v%0d done cyc", idx), 64'(wb_cyc_o), 64'd0);
    chk($sformatf("v%0d done stb", idx), 64'(wb_stb_o), 64'd0);
    if (!v.we) chk($sformatf("v%0d done rdat", idx), ddat_o, v.exp_rd);
    tick();
    chk($sformatf("v%0d idle dack", idx), 64'(dack_o), 64'd0);
    chk($sformatf("v%0d idle cyc", idx), 64'(wb_cyc_o), 64'd0);
    if (!v.we) chk($sformatf("v%0d hold rdat", idx), ddat_o, v.exp_rd);
  endtask

  initial begin
    //            siz   we    sgn   adr          wdat                    rlanes                  wt ea0          sel    nb exp_rd
    vecs[0] = '{2'd0, 1'b0, 1'b1, 64'h1001, 64'h0,                 64'h8000,               0, 64'h1001, 2'b10, 1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{2'd2, 1'b0, 1'b0, 64'h2000, 64'h0,                 64'h0000_0000_9ABC_5678, 0, 64'h2000, 2'b11, 2, 64'h0000_0000_9ABC_5678};
    vecs[2] = '{2'd3, 1'b1, 1'b0, 64'h3000, 64'h1122_3344_5566_7788, 64'h0,                 2, 64'h3000, 2'b11, 4, 64'h0};
    vecs[3] = '{2'd1, 1'b0, 1'b0, 64'h4003, 64'h0,                 64'hBEEF,               1, 64'h4002, 2'b11, 1, 64'h0000_0000_0000_BEEF};
    vecs[4] = '{2'd0, 1'b0, 1'b0, 64'h1000, 64'h0,                 64'h12F0,               0, 64'h1000, 2'b01, 1, 64'h0000_0000_0000_00F0};
    vecs[5] = '{2'd1, 1'b0, 1'b1, 64'h0010, 64'h0,                 64'h8001,               0, 64'h0010, 2'b11, 1, 64'hFFFF_FFFF_FFFF_8001};
    vecs[6] = '{2'd2, 1'b0, 1'b1, 64'h2006, 64'h0,                 64'h0000_0000_F000_0001, 1, 64'h2004, 2'b11, 2, 64'hFFFF_FFFF_F000_0001};
    vecs[7] = '{2'd0, 1'b1, 1'b0, 64'h5001, 64'h0000_0000_0000_00AB, 64'h0,                 0, 64'h5001, 2'b10, 1, 64'h0};
    vecs[8] = '{2'd3, 1'b0, 1'b1, 64'h6005, 64'h0,                 64'h4444_3333_2222_1111, 0, 64'h6000, 2'b11, 4, 64'h4444_3333_2222_1111};
    vecs[9] = '{2'd1, 1'b1, 1'b0, 64'h7001, 64'h0000_0000_0000_CAFE, 64'h0,                 1, 64'h7000, 2'b11, 1, 64'h0};

    reset_i = 1'b1; dcyc_i = 1'b0; dstb_i = 1'b0; dwe_i = 1'b0; dsiz_i = 2'd0;
    dsigned_i = 1'b0; dadr_i = '0; ddat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    tick();
    tick();
    chk("rst cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst stb", 64'(wb_stb_o), 64'd0);
    chk("rst we", 64'(wb_we_o), 64'd0);
    chk("rst sel", 64'(wb_sel_o), 64'd0);
    chk("rst adr", wb_adr_o, 64'd0);
    chk("rst wdat", 64'(wb_dat_o), 64'd0);
    chk("rst dack", 64'(dack_o), 64'd0);
    chk("rst rdat", ddat_o, 64'd0);
    reset_i = 1'b0;
    tick();

    // Stray acks while idle must not start anything.
    wb_ack_i = 1'b1; wb_dat_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stray%0d cyc", i), 64'(wb_cyc_o), 64'd0);
      chk($sformatf("stray%0d dack", i), 64'(dack_o), 64'd0);
    end
    wb_ack_i = 1'b0;

    // Back-to-back table vectors.
    for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

    // Ack held high through DONE: only one dack, no new beat.
    dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'd1; dsigned_i = 1'b1; dadr_i = 64'h20;
    tick();
    dcyc_i = 1'b0; dstb_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 16'h7FFF;
    tick();
    chk("ackdone dack", 64'(dack_o), 64'd1);
    chk("ackdone rdat", ddat_o, 64'h0000_0000_0000_7FFF);
    tick();
    chk("ackdone idle dack", 64'(dack_o), 64'd0);
    chk("ackdone idle cyc", 64'(wb_cyc_o), 64'd0);
    tick();
    chk("ackdone idle2 dack", 64'(dack_o), 64'd0);
    chk("ackdone idle2 cyc", 64'(wb_cyc_o), 64'd0);
    wb_ack_i = 1'b0;

    // Reset during the second beat of a dword read.
    dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'd3; dsigned_i = 1'b0; dadr_i = 64'h8000;
    tick();
    dcyc_i = 1'b0; dstb_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 16'hAAAA;
    tick();
    chk("rstmid b1 adr", wb_adr_o, 64'h8002);
    chk("rstmid b1 cyc", 64'(wb_cyc_o), 64'd1);
    reset_i = 1'b1; wb_dat_i = 16'hBBBB;
    tick();
    chk("rstmid cyc", 64'(wb_cyc_o), 64'd0);
    chk("rstmid stb", 64'(wb_stb_o), 64'd0);
    chk("rstmid dack", 64'(dack_o), 64'd0);
    reset_i = 1'b0; wb_ack_i = 1'b0;
    tick();
    chk("rstmid after dack", 64'(dack_o), 64'd0);
    chk("rstmid after cyc", 64'(wb_cyc_o), 64'd0);
    run_txn(10, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
